// File: rtl/mux_n_rr.sv
`default_nettype none
// ============================================================================
// Module : mux_n_rr
// Brief  : N-channel registered valid/ready multiplexer, fixed-select or
//          round-robin arbitration, one-entry output register.
// Rev    : 1.0  initial release
// ============================================================================
module mux_n_rr #(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           mode,
  input  logic [SW-1:0]  sel,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_chan,
  output logic           out_valid,
  input  logic           out_ready
);

  localparam logic [SW-1:0] c_LAST_RST = SW'(N - 1);

  logic [SW-1:0] last_q, last_d;
  logic [W-1:0]  data_q, data_d;
  logic [SW-1:0] chan_q, chan_d;
  logic          valid_q, valid_d;

  logic          w_load_en;
  logic          w_fx_hit;
  logic          w_rr_hi_hit, w_rr_lo_hit;
  logic [SW-1:0] w_rr_hi_idx, w_rr_lo_idx;
  logic          w_gnt_any;
  logic [SW-1:0] w_gnt_idx;
  logic [W-1:0]  w_gnt_word;
  logic          w_xfer;

  assign w_load_en = !valid_q || out_ready;

  // Round-robin splits into channels above last (searched first) and the
  // wrapped remainder; the lowest requesting index of each half wins.
  always_comb begin
    w_rr_hi_hit = 1'b0;
    w_rr_lo_hit = 1'b0;
    w_rr_hi_idx = '0;
    w_rr_lo_idx = '0;
    w_fx_hit    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (in_valid[i]) begin
        if (i > int'(last_q)) begin
          if (!w_rr_hi_hit) begin
            w_rr_hi_hit = 1'b1;
            w_rr_hi_idx = SW'(i);
          end
        end else if (!w_rr_lo_hit) begin
          w_rr_lo_hit = 1'b1;
          w_rr_lo_idx = SW'(i);
        end
        if (sel == SW'(i)) begin
          w_fx_hit = 1'b1;
        end
      end
    end
  end

  always_comb begin
    if (mode) begin
      w_gnt_any = w_rr_hi_hit || w_rr_lo_hit;
      w_gnt_idx = w_rr_hi_hit ? w_rr_hi_idx : w_rr_lo_idx;
    end else begin
      w_gnt_any = w_fx_hit;
      w_gnt_idx = sel;
    end
  end

  always_comb begin
    w_gnt_word = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt_idx == SW'(i)) begin
        w_gnt_word = in_data[i*W +: W];
      end
    end
  end

  assign w_xfer   = w_load_en && w_gnt_any;
  assign in_ready = w_xfer ? (N'(1) << w_gnt_idx) : '0;

  always_comb begin
    last_d  = last_q;
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    if (w_xfer) begin
      data_d  = w_gnt_word;
      chan_d  = w_gnt_idx;
      valid_d = 1'b1;
      if (mode) begin
        last_d = w_gnt_idx;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q  <= c_LAST_RST;
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      last_q  <= last_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
    end
  end

  assign out_data  = data_q;
  assign out_chan  = chan_q;
  assign out_valid = valid_q;

endmodule
`default_nettype wire
